// File: rtl/bram_arb_pkg.sv
// Shared definitions for the frame/scratch BRAM arbiter and the display
// buffer updater: FSM state encoding, read-owner encoding, default bus
// widths and a counter-width helper.
package bram_arb_pkg;

    // Arbiter FSM states: open arbitration or updater-held lock.
    typedef enum logic {
        S_OPEN = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    // Owner tag carried with an issued read so the data returns to the right port.
    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_t;

    // Default BRAM geometry, shared with the display buffer updater.
    localparam int BRAM_ADDR_W = 16;
    localparam int BRAM_DATA_W = 1;

    // Width of a counter that must hold 0..max without wrapping.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/bram_arb_rdpipe.sv
// One-stage read-return register. Remembers whether a read was issued last
// cycle and which port issued it, then steers the BRAM's registered dout to
// that port. Reset drops any read still in flight.
module bram_arb_rdpipe
    import bram_arb_pkg::*;
#(
    parameter int DATA_W = BRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_issue,
    input  owner_t            rd_owner,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata
);

    logic   issued_q;
    owner_t owner_q;

    // Capture the read-issued flag and its owner tag for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= 1'b0;
            owner_q  <= OWN_P0;
        end else begin
            issued_q <= rd_issue;
            owner_q  <= rd_owner;
        end
    end

    // A reset in the return cycle suppresses the return as well.
    assign p0_rvalid = issued_q && (owner_q == OWN_P0) && !rst;
    assign p1_rvalid = issued_q && (owner_q == OWN_P1) && !rst;
    assign p0_rdata  = p0_rvalid ? mem_dout : '0;
    assign p1_rdata  = p1_rvalid ? mem_dout : '0;

endmodule

// File: rtl/bram_arb.sv
// Two-requester arbiter for the shared single-port frame/scratch BRAM.
// p0 = display fetch (read only, latency-critical), p1 = game/buffer updater
// (reads, writes, locked read-modify-write bursts).
//
// Handshake: a requester raises req with addr/we/din stable and holds them
// until gnt; gnt is combinational and the access happens in the gnt cycle.
// A granted read returns rvalid/rdata exactly one cycle later. Writes never
// return rvalid. At most one gnt is high per cycle.
//
// Build option BRAM_ARB_RR_EN: open arbitration becomes strict round-robin
// (last-granted port loses a tie) and the starvation counter is removed.
// Default build: p0 priority with a starvation guard for p1.
module bram_arb
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W     = BRAM_ADDR_W,
    parameter int DATA_W     = BRAM_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_din,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              lock_abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output state_t            dbg_state
);

    localparam int LW = cnt_w(LOCK_MAX);

    state_t            state;
    logic [LW-1:0]     lock_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              arb_open;
    logic              lock_expire;
    logic              p1_first;

`ifdef BRAM_ARB_RR_EN
    owner_t last_q;

    // Remember the last granted port so it loses the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_P1;
        end else if (p0_gnt) begin
            last_q <= OWN_P0;
        end else if (p1_gnt) begin
            last_q <= OWN_P1;
        end
    end
`else
    localparam int SW = cnt_w(STARVE_MAX);
    logic [SW-1:0] starve_cnt;

    // Count consecutive denied p1 cycles, saturating; any p1 grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (p1_gnt) begin
            starve_cnt <= '0;
        end else if (p1_req && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    // Grant decision: open arbitration, lock ownership, or forced lock release.
    always_comb begin
        p0_gnt      = 1'b0;
        p1_gnt      = 1'b0;
        lock_abort  = 1'b0;
        // Dropping p1_lock makes the exit cycle an ordinary open cycle.
        arb_open    = (state == S_OPEN) || !p1_lock;
        lock_expire = (state == S_LOCK) && p1_lock && (lock_cnt == LW'(LOCK_MAX - 1));
`ifdef BRAM_ARB_RR_EN
        p1_first    = (last_q == OWN_P0);
`else
        p1_first    = (starve_cnt == SW'(STARVE_MAX));
`endif
        if (!rst) begin
            if (arb_open) begin
                if (p1_req && (p1_first || !p0_req)) begin
                    p1_gnt = 1'b1;
                end else begin
                    p0_gnt = p0_req;
                end
            end else if (lock_expire) begin
                // p1 is denied on the release cycle so p0 gets in immediately.
                lock_abort = 1'b1;
                p0_gnt     = p0_req;
            end else begin
                p1_gnt = p1_req;
            end
        end
    end

    // BRAM bus follows the granted port; idle cycles hold the last address.
    assign mem_addr = p0_gnt ? p0_addr : (p1_gnt ? p1_addr : addr_q);
    assign mem_din  = p1_gnt ? p1_din : din_q;
    assign mem_we   = p1_gnt && p1_we;

    // Hold the last driven address/data for idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            addr_q <= mem_addr;
            din_q  <= mem_din;
        end
    end

    // Lock FSM: enter on a locked p1 grant, leave when the lock drops or expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_OPEN;
            lock_cnt <= '0;
        end else begin
            case (state)
                S_OPEN: begin
                    if (p1_gnt && p1_lock) begin
                        state    <= S_LOCK;
                        lock_cnt <= '0;
                    end
                end
                S_LOCK: begin
                    if (!p1_lock || lock_expire) begin
                        state    <= S_OPEN;
                        lock_cnt <= '0;
                    end else if (lock_cnt != LW'(LOCK_MAX - 1)) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_OPEN;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    bram_arb_rdpipe #(
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .rd_issue  (p0_gnt || (p1_gnt && !p1_we)),
        .rd_owner  (p1_gnt ? OWN_P1 : OWN_P0),
        .mem_dout  (mem_dout),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata)
    );

endmodule

// File: tb/tb_bram_arb.sv
// Bench for bram_arb: behavioural BRAM, a spec-level arbitration/memory
// model checked every cycle, and directed scenarios with literal expectations.
module tb_bram_arb;
    import bram_arb_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 1;
    localparam int STARVE_MAX = 4;
    localparam int LOCK_MAX   = 32;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;
    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_din;
    logic              p1_lock;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;
    logic              lock_abort;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;
    state_t            dbg_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    bram_arb #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .LOCK_MAX   (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_gnt     (p0_gnt),
        .p0_rvalid  (p0_rvalid),
        .p0_rdata   (p0_rdata),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_din     (p1_din),
        .p1_lock    (p1_lock),
        .p1_gnt     (p1_gnt),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .lock_abort (lock_abort),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout),
        .dbg_state  (dbg_state)
    );

    // ---------------- behavioural BRAM (environment) ----------------
    logic [DATA_W-1:0] bram [0:DEPTH-1];
    bit   [DATA_W-1:0] exp_mem [0:DEPTH-1];

    always @(posedge clk) begin
        if (mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model + scoreboard ----------------
    bit                m_locked = 0;
    int                m_starve = 0;
    int                m_lcnt   = 0;
    logic [ADDR_W-1:0] m_last_addr = '0;
    logic [DATA_W:0]   exp_q[$];   // {owner, data}, one entry per issued read
    bit                m_g0, m_g1, m_ab, m_open, m_rv0, m_rv1;
    logic [DATA_W-1:0] m_rd0, m_rd1;
    logic [ADDR_W-1:0] m_ea;
    logic [DATA_W:0]   m_e;

    always @(negedge clk) begin
        if (chk_en) begin
            m_g0 = 0; m_g1 = 0; m_ab = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
            if (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                if (!rst) begin
                    if (m_e[DATA_W]) begin m_rv1 = 1; m_rd1 = m_e[DATA_W-1:0]; end
                    else             begin m_rv0 = 1; m_rd0 = m_e[DATA_W-1:0]; end
                end
            end
            if (!rst) begin
                m_open = !m_locked || !p1_lock;
                if (m_open) begin
                    if (p1_req && (m_starve >= STARVE_MAX || !p0_req)) m_g1 = 1;
                    else m_g0 = p0_req;
                end else if (m_lcnt == LOCK_MAX - 1) begin
                    m_ab = 1;
                    m_g0 = p0_req;
                end else begin
                    m_g1 = p1_req;
                end
            end
            m_ea = m_g0 ? p0_addr : (m_g1 ? p1_addr : m_last_addr);

            check("m_p0_gnt", p0_gnt, m_g0);
            check("m_p1_gnt", p1_gnt, m_g1);
            check("m_lock_abort", lock_abort, m_ab);
            check("m_mem_we", mem_we, m_g1 && p1_we);
            check("m_mem_addr", mem_addr, m_ea);
            if (m_g1 && p1_we) check("m_mem_din", mem_din, p1_din);
            check("m_p0_rvalid", p0_rvalid, m_rv0);
            check("m_p1_rvalid", p1_rvalid, m_rv1);
            if (m_rv0) check("m_p0_rdata", p0_rdata, m_rd0);
            if (m_rv1) check("m_p1_rdata", p1_rdata, m_rd1);

            if (rst) begin
                m_locked = 0; m_starve = 0; m_lcnt = 0; m_last_addr = '0;
                exp_q.delete();
            end else begin
                if (m_g0) exp_q.push_back({1'b0, exp_mem[p0_addr]});
                if (m_g1 && !p1_we) exp_q.push_back({1'b1, exp_mem[p1_addr]});
                if (m_g1 && p1_we) exp_mem[p1_addr] = p1_din;
                if (m_g0 || m_g1) m_last_addr = m_ea;
                if (m_g1) m_starve = 0;
                else if (p1_req && m_starve < STARVE_MAX) m_starve++;
                if (!m_locked) begin
                    if (m_g1 && p1_lock) begin m_locked = 1; m_lcnt = 0; end
                end else if (m_open || m_ab) begin
                    m_locked = 0;
                end else begin
                    m_lcnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_addr = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_din = '0; p1_lock = 0;
    endtask

    // ---------------- directed scenarios ----------------
    int n_p1;
    int n_ab;
    logic [3:0] pre;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = '0;
            exp_mem[i] = '0;
        end
        pre = 4'b1101;   // addr0=1, addr1=0, addr2=1, addr3=1
        for (int i = 0; i < 4; i++) begin
            bram[i]    = pre[i];
            exp_mem[i] = pre[i];
        end
        idle_inputs();
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        rst = 0;

        // Reset state
        @(negedge clk);
        check("rst_p0_gnt", p0_gnt, 0);
        check("rst_p1_gnt", p1_gnt, 0);
        check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_lock_abort", lock_abort, 0);
        check("rst_state", dbg_state, S_OPEN);
        tick();

        // p0-only streaming reads of addr 0..3
        for (int k = 0; k < 5; k++) begin
            p0_req = (k < 4); p0_addr = ADDR_W'(k);
            @(negedge clk);
            if (k < 4) check("t1_p0_gnt", p0_gnt, 1);
            if (k >= 1) begin
                check("t1_p0_rvalid", p0_rvalid, 1);
                check("t1_p0_rdata", p0_rdata, pre[k-1]);
            end
            check("t1_p1_rvalid", p1_rvalid, 0);
            tick();
        end
        idle_inputs();

        // Both requesting continuously: p1 wins every 5th cycle
        p0_req = 1; p0_addr = 16'd5;
        p1_req = 1; p1_we = 0; p1_addr = 16'd7;
        n_p1 = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("t2_p1_gnt", p1_gnt, (k % 5 == 4));
            check("t2_p0_gnt", p0_gnt, (k % 5 != 4));
            n_p1 += int'(p1_gnt);
            tick();
        end
        check("t2_p1_count", n_p1, 3);
        idle_inputs();
        tick();

        // p1 write then p0 read of the same address
        p1_req = 1; p1_we = 1; p1_addr = 16'd100; p1_din = 1'b1;
        @(negedge clk);
        check("t3_p1_gnt", p1_gnt, 1);
        check("t3_mem_we", mem_we, 1);
        tick();
        idle_inputs();
        p0_req = 1; p0_addr = 16'd100;
        @(negedge clk);
        check("t3_p0_gnt", p0_gnt, 1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t3_p0_rvalid", p0_rvalid, 1);
        check("t3_p0_rdata", p0_rdata, 1);
        tick();

        // Locked burst of 6 writes, p0 shut out until the lock drops
        for (int k = 0; k < 6; k++) begin
            p0_req = (k > 0); p0_addr = 16'd3;
            p1_req = 1; p1_lock = 1; p1_we = 1; p1_addr = ADDR_W'(200 + k); p1_din = DATA_W'(k);
            @(negedge clk);
            check("t4_p1_gnt", p1_gnt, 1);
            check("t4_p0_gnt", p0_gnt, 0);
            check("t4_lock_abort", lock_abort, 0);
            tick();
        end
        p1_lock = 0; p1_we = 0; p1_addr = 16'd201;
        @(negedge clk);
        check("t4_p0_after_lock", p0_gnt, 1);
        check("t4_p1_after_lock", p1_gnt, 0);
        check("t4_abort_after", lock_abort, 0);
        tick();
        idle_inputs();
        tick();

        // Lock held for 40 cycles: forced release after 32 cycles in S_LOCK
        n_ab = 0;
        for (int k = 0; k < 40; k++) begin
            p0_req = (k > 0); p0_addr = 16'd2;
            p1_req = 1; p1_lock = 1; p1_we = 0; p1_addr = ADDR_W'(k % 4);
            @(negedge clk);
            n_ab += int'(lock_abort);
            if (k >= 1 && k < 32) check("t5_p0_locked_out", p0_gnt, 0);
            if (k == 32) begin
                check("t5_abort", lock_abort, 1);
                check("t5_p0_on_abort", p0_gnt, 1);
                check("t5_p1_on_abort", p1_gnt, 0);
            end
            if (k == 36) check("t5_p1_relock", p1_gnt, 1);
            tick();
        end
        check("t5_abort_count", n_ab, 1);
        idle_inputs();
        tick();

        // Reset right after a locked p1 read grant
        p1_req = 1; p1_lock = 1; p1_we = 0; p1_addr = 16'd1;
        @(negedge clk);
        check("t6_p1_gnt", p1_gnt, 1);
        tick();
        rst = 1; p1_req = 0;
        @(negedge clk);
        check("t6_no_rvalid", p1_rvalid, 0);
        tick();
        rst = 0;
        @(negedge clk);
        check("t6_gnt", {p0_gnt, p1_gnt}, 0);
        check("t6_rvalid", {p0_rvalid, p1_rvalid}, 0);
        check("t6_rdata", {p0_rdata, p1_rdata}, 0);
        check("t6_mem_addr", mem_addr, 0);
        check("t6_mem_we", mem_we, 0);
        check("t6_lock_abort", lock_abort, 0);
        check("t6_state", dbg_state, S_OPEN);
        tick();
        p0_req = 1; p0_addr = 16'd0; p1_req = 1;
        @(negedge clk);
        check("t6_p0_after_rst", p0_gnt, 1);
        tick();
        idle_inputs();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arb.md
Name: bram_arb

Overview:
- Two-requester arbiter and sequencer for the shared single-port frame/scratch BRAM (1-bit words, one address/din/we bus, registered dout with 1-cycle read latency).
- Requester 0 is the display fetch path, serving the panel driver's pixel requests; it is latency-critical.
- Requester 1 is the game/buffer updater. It issues reads, writes and locked read-modify-write bursts.
- The block sits between both requesters and the BRAM. It owns the BRAM address, din and we.

Parameters:
- ADDR_W, 16, BRAM address width.
- DATA_W, 1, BRAM word width.
- STARVE_MAX, 4, consecutive cycles P1 may be denied before it gets forced priority for one grant.
- LOCK_MAX, 32, maximum cycles P1 may hold a lock before forced release.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- p0_req  in  1  display access request (read only).
- p0_addr  in  ADDR_W  display address.
- p0_gnt  out  1  p0 request accepted this cycle.
- p0_rvalid  out  1  p0_rdata valid.
- p0_rdata  out  DATA_W  read data to display path.
- p1_req  in  1  updater access request.
- p1_we  in  1  1 = write, 0 = read.
- p1_addr  in  ADDR_W  updater address.
- p1_din  in  DATA_W  updater write data.
- p1_lock  in  1  hold exclusive ownership after the current grant.
- p1_gnt  out  1  p1 request accepted this cycle.
- p1_rvalid  out  1  p1_rdata valid.
- p1_rdata  out  DATA_W  read data to updater.
- lock_abort  out  1  one-cycle pulse when a lock is force-released.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_we  out  1  BRAM write enable.
- mem_dout  in  DATA_W  BRAM read data, valid 1 cycle after address.

Behaviour:
- Grant timing:
  - Grants are combinational from req and registered state, issued in the same cycle.
  - mem_addr/din/we are driven from the granted port that cycle.
  - With no grant: mem_we = 0 and mem_addr holds its last value.
  - At most one gnt is high per cycle. A requester holds req/addr/we/din stable until gnt.
- Read return:
  - A granted read produces pNx_rvalid exactly 1 cycle later, with pN_rdata = mem_dout.
  - Owner tag is a 1-bit register; read-issued flag is a 1-bit register.
  - A write never produces rvalid.
- States:
  - S_OPEN, normal arbitration:
    - p0 wins by default.
    - starve_cnt increments each cycle p1_req is high and p1 is not granted; it saturates at STARVE_MAX.
    - When starve_cnt == STARVE_MAX and p1_req is high, p1 wins that cycle regardless of p0.
    - starve_cnt clears on any p1 grant.
  - A p1 grant with p1_lock = 1 moves to S_LOCK and clears lock_cnt.
  - S_LOCK:
    - Only p1 can be granted; p0_gnt is held 0.
    - lock_cnt increments every cycle.
    - Exit to S_OPEN on the first cycle p1_lock is low. That cycle is arbitrated as S_OPEN, so p0 may win it.
    - If lock_cnt reaches LOCK_MAX-1 with p1_lock still high: exit to S_OPEN, pulse lock_abort for 1 cycle, and deny p1 for that cycle.
- Simultaneous events:
  - p0 and p1 request in the same cycle with starve_cnt < STARVE_MAX: p0 wins.
  - A p1 lock request on a forced-starvation grant is honoured.
- Reset values: state = S_OPEN; starve_cnt = 0; lock_cnt = 0; rvalid flags = 0; rdata = 0; mem_addr = 0; mem_we = 0; lock_abort = 0.
- Reset mid-operation: an in-flight read is dropped (no rvalid) and any lock is released without lock_abort.
- Counter widths: sized as $clog2(max+1) and never wrap.

Optional Feature:
- Macro BRAM_ARB_RR_EN.
- Defined: S_OPEN uses strict round-robin.
  - The last-granted port loses any tie.
  - STARVE_MAX and starve_cnt are removed.
  - Lock behaviour is unchanged.
- Undefined: priority-with-starvation-guard as specified above.

Decomposition:
- Shared package bram_arb_pkg holds:
  - state encoding (S_OPEN, S_LOCK);
  - owner encoding (OWN_P0 = 0, OWN_P1 = 1);
  - default ADDR_W/DATA_W constants shared with the display buffer updater.
- One natural sub-module: bram_arb_rdpipe, the 1-stage owner-tagged read-return register that routes mem_dout to p0/p1.

Test Plan:
- p0 only, addr 0..3 on consecutive cycles, memory preloaded 1,0,1,1 -> p0_gnt high all 4 cycles; p0_rvalid on cycles 1..4 with rdata 1,0,1,1; p1_rvalid never high.
- p0_req and p1_req both held high continuously, STARVE_MAX = 4 -> p1 granted on exactly every 5th cycle (cycles 4, 9, 14…); the rest go to p0.
- p1 write addr 100 din 1, then p0 read addr 100 the next cycle -> p0_rdata = 1 with rvalid one cycle after the read grant.
- p1 lock held for 6 grants with p0_req high throughout -> p0_gnt = 0 for those 6 cycles; p0 granted on the first cycle after p1_lock drops; lock_abort stays 0.
- p1_lock held for 40 cycles, LOCK_MAX = 32 -> forced exit after 32 cycles in S_LOCK; lock_abort pulses once; p0 granted that cycle.
- rst asserted the cycle after a p1 read grant -> no p1_rvalid; all outputs at reset values on the next cycle.
